// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - debounced key pulses with auto-repeat, plus slow clock divider
module key_pulse_gen #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 2500,
  parameter int HOLD_CYCLES   = 50000,
  parameter int REPEAT_CYCLES = 10000,
  parameter int DIV_HALF      = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_KEYS-1:0] rpt_en,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] rpt,
  output logic              clk_div,
  output logic              div_tick
);

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW   = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
  localparam int HW   = ($clog2(HMAX) < 1) ? 1 : $clog2(HMAX);
  localparam int CW   = ($clog2(DIV_HALF) < 1) ? 1 : $clog2(DIV_HALF);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_HALF - 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] first;
  logic [DW-1:0]     dc [N_KEYS];
  logic [HW-1:0]     hc [N_KEYS];
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      s1            <= '0;
      s2            <= '0;
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      rpt           <= '0;
      first         <= '1;
      for (int i = 0; i < N_KEYS; i++) begin
        dc[i] <= '0;
        hc[i] <= '0;
      end
    end else begin
      s1            <= ~key_n;
      s2            <= s1;
      press         <= '0;
      release_pulse <= '0;
      rpt           <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == level[i]) begin
          dc[i] <= '0;
        end else if (dc[i] != DEB_LAST) begin
          dc[i] <= dc[i] + 1'b1;
        end else begin
          dc[i]    <= '0;
          level[i] <= s2[i];
        end

        // Accepted level change takes priority over repeat timing, so a
        // release edge can never also emit a repeat.
        if (s2[i] != level[i] && dc[i] == DEB_LAST) begin
          press[i]         <= s2[i];
          release_pulse[i] <= ~s2[i];
          hc[i]            <= '0;
          first[i]         <= 1'b1;
        end else if (level[i] && rpt_en[i]) begin
          if (hc[i] == (first[i] ? HOLD_LAST : REP_LAST)) begin
            press[i] <= 1'b1;
            rpt[i]   <= 1'b1;
            hc[i]    <= '0;
            first[i] <= 1'b0;
          end else begin
            hc[i] <= hc[i] + 1'b1;
          end
        end else begin
          hc[i]    <= '0;
          first[i] <= 1'b1;
        end
      end
    end
  end

  // Counter parks at 0 while idle so the first enabled cycle toggles at once.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt      <= '0;
      clk_div  <= 1'b1;
      div_tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt      <= DIV_LAST;
      clk_div  <= ~clk_div;
      div_tick <= 1'b1;
    end else begin
      cnt      <= cnt - 1'b1;
      div_tick <= 1'b0;
    end
  end

endmodule
